// File: rtl/mux4_rr_arb_if.sv
// Handshake bundle between the four requesters, the round-robin arbiter and
// the downstream consumer.
//   req       : request vector, bit i belongs to requester i
//   a,b,c,d   : operands of requesters 0..3
//   gnt       : one-hot same-cycle grant (operand captured at this edge)
//   out_vld   : output slot holds a valid word
//   out_rdy   : consumer accepts the word this cycle
//   out_data  : registered selected word
//   out_src   : index of the requester that produced out_data
// master = requesters + consumer side, slave = arbiter side.
interface mux4_rr_arb_if #(
  parameter int W = 16
);
  logic [3:0]   req;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic [3:0]   gnt;
  logic         out_vld;
  logic         out_rdy;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;

  modport master (
    output req, a, b, c, d, out_rdy,
    input  gnt, out_vld, out_data, out_src
  );

  modport slave (
    input  req, a, b, c, d, out_rdy,
    output gnt, out_vld, out_data, out_src
  );
endinterface

// File: rtl/mux4_rr_arb.sv
// Round-robin arbiter and registered output slot for the shared 4:1 select
// datapath. Each cycle at most one requester wins; its operand is captured
// into a one-entry valid/ready slot. A winner may keep priority for up to
// BURST consecutive beats before the pointer rotates past it.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mux4_rr_arb_if.slave (req, a..d, gnt, out_vld/out_rdy,
//          out_data, out_src)
// BURST legal range 1..15; W is the data width and must match bus.W.
module mux4_rr_arb #(
  parameter int BURST = 4,
  parameter int W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  mux4_rr_arb_if.slave    bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  localparam logic [3:0] BURST_L = 4'(BURST);

  slot_e        slot_q, slot_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   owner_q, owner_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [W-1:0] data_q, data_d;
  logic [1:0]   src_q, src_d;

  logic         load;
  logic         found;
  logic [1:0]   win;
  logic [1:0]   idx;
  logic [3:0]   cnt_n;
  logic [W-1:0] sel;

  // Priority search starting at ptr and wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    unique case (win)
      2'd0:    sel = bus.a;
      2'd1:    sel = bus.b;
      2'd2:    sel = bus.c;
      default: sel = bus.d;
    endcase
  end

  always_comb begin
    load    = (slot_q == EMPTY) || bus.out_rdy;
    cnt_n   = ((win == owner_q) && (cnt_q != '0)) ? cnt_q + 4'd1 : 4'd1;

    slot_d  = slot_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    src_d   = src_q;
    bus.gnt = '0;

    if (load) begin
      if (found) begin
        bus.gnt[win] = !rst;
        slot_d       = FULL;
        data_d       = sel;
        src_d        = win;
        owner_d      = win;
        // Pointer parks on the winner so it keeps priority until the burst
        // completes; only then does it move past the winner.
        if (cnt_n == BURST_L) begin
          ptr_d = win + 2'd1;
          cnt_d = '0;
        end else begin
          ptr_d = win;
          cnt_d = cnt_n;
        end
      end else begin
        slot_d = EMPTY;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= EMPTY;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      slot_q  <= slot_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign bus.out_vld  = (slot_q == FULL);
  assign bus.out_data = data_q;
  assign bus.out_src  = src_q;

endmodule

// File: tb/tb_mux4_rr_arb.sv
module tb_mux4_rr_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  req_s = '0;
  logic [15:0] a_s = '0, b_s = '0, c_s = '0, d_s = '0;
  logic        rdy_s = 1'b0;

  mux4_rr_arb_if #(.W(16)) bus4 ();
  mux4_rr_arb_if #(.W(16)) bus1 ();

  assign bus4.req = req_s;  assign bus1.req = req_s;
  assign bus4.a = a_s;      assign bus1.a = a_s;
  assign bus4.b = b_s;      assign bus1.b = b_s;
  assign bus4.c = c_s;      assign bus1.c = c_s;
  assign bus4.d = d_s;      assign bus1.d = d_s;
  assign bus4.out_rdy = rdy_s;
  assign bus1.out_rdy = rdy_s;

  mux4_rr_arb #(.BURST(4), .W(16)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mux4_rr_arb #(.BURST(1), .W(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          mon_en   = 1'b0;

  typedef struct packed {
    logic [1:0]  src;
    logic [15:0] data;
  } item_t;

  item_t q0[$];
  item_t q1[$];

  // Reference model state, index 0 -> BURST=4 instance, 1 -> BURST=1.
  int burst_of[2] = '{4, 1};
  int mptr[2]  = '{0, 0};
  int mown[2]  = '{0, 0};
  int mcnt[2]  = '{0, 0};
  bit mvld[2]  = '{0, 0};
  int pw[2]    = '{-1, -1};
  bit pload[2] = '{0, 0};
  bit prst     = 1'b1;

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", nm, k, $time, act, exp);
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int j = 0; j < 4; j++) begin
      int ix;
      ix = (p + j) % 4;
      if (r[ix]) return ix;
    end
    return -1;
  endfunction

  task automatic q_push(input int k, input item_t it);
    if (k == 0) q0.push_back(it); else q1.push_back(it);
  endtask

  task automatic q_clear(input int k);
    if (k == 0) q0.delete(); else q1.delete();
  endtask

  // Apply the spec's state-update rules for the decision taken last cycle.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (prst) begin
        mptr[k] = 0; mown[k] = 0; mcnt[k] = 0; mvld[k] = 1'b0;
      end else if (pload[k]) begin
        if (pw[k] >= 0) begin
          int n;
          n = (pw[k] == mown[k] && mcnt[k] != 0) ? mcnt[k] + 1 : 1;
          mown[k] = pw[k];
          mvld[k] = 1'b1;
          if (n == burst_of[k]) begin
            mptr[k] = (pw[k] + 1) % 4;
            mcnt[k] = 0;
          end else begin
            mptr[k] = pw[k];
            mcnt[k] = n;
          end
        end else begin
          mvld[k] = 1'b0;
          mcnt[k] = 0;
        end
      end
    end
  endtask

  task automatic apply(input logic r, input logic [3:0] rq, input logic rdy,
                       input logic [15:0] va, input logic [15:0] vb,
                       input logic [15:0] vc, input logic [15:0] vd);
    logic [15:0] ops[4];
    logic [3:0]  eg[2];
    @(posedge clk);
    model_edge();
    #1;
    rst = r; req_s = rq; rdy_s = rdy;
    a_s = va; b_s = vb; c_s = vc; d_s = vd;
    ops[0] = va; ops[1] = vb; ops[2] = vc; ops[3] = vd;
    prst = r;
    for (int k = 0; k < 2; k++) begin
      eg[k] = '0;
      if (r) begin
        pw[k] = -1; pload[k] = 1'b0;
        q_clear(k);
      end else begin
        pload[k] = !mvld[k] || rdy;
        pw[k] = pload[k] ? pick(rq, mptr[k]) : -1;
        if (pw[k] >= 0) begin
          item_t it;
          it.src  = 2'(pw[k]);
          it.data = ops[pw[k]];
          eg[k][pw[k]] = 1'b1;
          q_push(k, it);
        end
      end
    end
    #1;
    chk("gnt", 0, 32'(bus4.gnt), 32'(eg[0]));
    chk("gnt", 1, 32'(bus1.gnt), 32'(eg[1]));
  endtask

  task automatic mon(input int k, input logic vld, input logic [15:0] data,
                     input logic [1:0] src);
    int sz;
    item_t fr;
    chk("out_vld", k, 32'(vld), 32'(mvld[k]));
    if (!rst && vld === 1'b1) begin
      sz = (k == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        n_checks++;
        $display("FAIL sb_empty dut%0d t=%0t actual=%h/%h expected=none", k, $time, src, data);
      end else begin
        fr = (k == 0) ? q0[0] : q1[0];
        chk("out_word", k, 32'({src, data}), 32'(fr));
        if (rdy_s) begin
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, bus4.out_vld, bus4.out_data, bus4.out_src);
      mon(1, bus1.out_vld, bus1.out_data, bus1.out_src);
    end
  end

  initial begin
    // Reset with all requests high: no grant may leak through.
    apply(1, 4'hF, 1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    apply(1, 4'hF, 1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    @(negedge clk);
    chk("rst_vld",  0, 32'(bus4.out_vld),  0);
    chk("rst_data", 0, 32'(bus4.out_data), 0);
    chk("rst_src",  0, 32'(bus4.out_src),  0);
    chk("rst_vld",  1, 32'(bus1.out_vld),  0);
    chk("rst_data", 1, 32'(bus1.out_data), 0);
    chk("rst_src",  1, 32'(bus1.out_src),  0);
    mon_en = 1'b1;

    // Single requester.
    for (int i = 0; i < 4; i++) apply(0, 4'b0010, 1, 16'h0, 16'h1234, 16'h0, 16'h0);

    // Fresh reset, then all four requesting: round-robin / bursts.
    apply(1, 4'h0, 1, 16'h0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 12; i++)
      apply(0, 4'hF, 1, 16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0);

    // Requester 1 drops after its 2nd beat of a burst.
    apply(1, 4'h0, 1, 16'h0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 6; i++)
      apply(0, 4'hF, 1, 16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0);
    for (int i = 0; i < 8; i++)
      apply(0, 4'b1101, 1, 16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0);

    // Backpressure then drain-and-fill without a bubble.
    apply(0, 4'b0001, 1, 16'h1234, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) apply(0, 4'b0001, 0, 16'h1234, 16'h0, 16'h0, 16'h0);
    apply(0, 4'b0001, 1, 16'h5555, 16'h0, 16'h0, 16'h0);
    apply(0, 4'b0000, 1, 16'h5555, 16'h0, 16'h0, 16'h0);

    // Idle mid-burst, then reset while FULL.
    for (int i = 0; i < 2; i++) apply(0, 4'hF, 1, 16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0);
    for (int i = 0; i < 2; i++) apply(0, 4'h0, 1, 16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0);
    for (int i = 0; i < 3; i++) apply(0, 4'hE, 0, 16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0);
    apply(1, 4'hF, 0, 16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0);
    apply(0, 4'hF, 1, 16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0);
    chk("post_rst_gnt", 0, 32'(bus4.gnt), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom % 97) == 0, 4'($urandom), ($urandom % 4) != 0,
            16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 3; i++) apply(0, 4'h0, 1, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
